// File: rtl/secuenciador_led_pkg.sv
// Shared types and widths for the LED reaction game (state encoding, score/lives widths).
package secuenciador_led_pkg;

    localparam int PUNTOS_W = 4;
    localparam int VIDAS_W  = 2;
    localparam int DEB_W    = 4;
    localparam logic [DEB_W-1:0] DEB_MAX = 4'd15;
    localparam logic [15:0] PAT_PAR_16 = 16'h5555;

    typedef enum logic [2:0] {
        INICIO  = 3'd0,
        BARRIDO = 3'd1,
        ACIERTO = 3'd2,
        FALLO   = 3'd3,
        FIN     = 3'd4
    } estado_t;

    typedef enum logic {
        SUBE = 1'b0,
        BAJA = 1'b1
    } dir_t;

endpackage

// File: rtl/secuenciador_led_sincronizador_flanco.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge detector.
module sincronizador_flanco (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic nivel,
    output logic flanco
);

    logic s1, s2, s3;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= entrada;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Combinational pulse so the consumer acts on the third edge after the input rise.
    assign nivel  = s2;
    assign flanco = s2 & ~s3;

endmodule

// File: rtl/secuenciador_led.sv
// LED sweep reaction game: press the button when the lit LED is the target one.
// Optional button debounce filter enabled with macro SECUENCIADOR_LED_ANTIREBOTE_EN.
module secuenciador_led
    import secuenciador_led_pkg::*;
#(
    parameter int N_LEDS      = 8,
    parameter int OBJETIVO    = 3,
    parameter int VIDAS       = 3,
    parameter int FLASH_PASOS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                paso,
    input  logic                boton,
    output logic [N_LEDS-1:0]   leds,
    output logic [PUNTOS_W-1:0] puntos,
    output logic [VIDAS_W-1:0]  vidas,
    output logic                fin
);

    localparam int PW = $clog2(N_LEDS);
    localparam int FW = $clog2(FLASH_PASOS) + 1;
    localparam logic [PW-1:0]      POS_MAX   = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]      POS_OBJ   = PW'(OBJETIVO);
    localparam logic [FW-1:0]      FLASH_FIN = FW'(FLASH_PASOS - 1);
    localparam logic [VIDAS_W-1:0] VIDAS_INI = VIDAS_W'(VIDAS);
    localparam logic [N_LEDS-1:0]  PAT_PAR   = N_LEDS'(PAT_PAR_16);
    localparam logic [N_LEDS-1:0]  PAT_IMPAR = ~PAT_PAR;

    logic paso_nivel, paso_pulso;
    logic boton_nivel, boton_flanco, boton_pulso;

    sincronizador_flanco u_sinc_paso (
        .clock   (clock),
        .reset   (reset),
        .entrada (paso),
        .nivel   (paso_nivel),
        .flanco  (paso_pulso)
    );

    sincronizador_flanco u_sinc_boton (
        .clock   (clock),
        .reset   (reset),
        .entrada (boton),
        .nivel   (boton_nivel),
        .flanco  (boton_flanco)
    );

`ifdef SECUENCIADOR_LED_ANTIREBOTE_EN
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_hecho;

    // Level must stay high 16 clocks; one pulse per press, release rearms.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_cnt   <= '0;
            deb_hecho <= 1'b0;
        end else if (!boton_nivel) begin
            deb_cnt   <= '0;
            deb_hecho <= 1'b0;
        end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + 1'b1;
        end else if (boton_pulso) begin
            deb_hecho <= 1'b1;
        end
    end

    assign boton_pulso = boton_nivel && (deb_cnt == DEB_MAX) && !deb_hecho;

    logic unused_ok;
    assign unused_ok = &{1'b0, paso_nivel, boton_flanco};
`else
    assign boton_pulso = boton_flanco;

    logic unused_ok;
    assign unused_ok = &{1'b0, paso_nivel, boton_nivel};
`endif

    estado_t             estado, estado_n;
    dir_t                dir, dir_n;
    logic [PW-1:0]       pos, pos_n;
    logic [FW-1:0]       cnt, cnt_n;
    logic [PUNTOS_W-1:0] puntos_n;
    logic [VIDAS_W-1:0]  vidas_n;
    logic [N_LEDS-1:0]   leds_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIO;
            dir    <= SUBE;
            pos    <= '0;
            cnt    <= '0;
            puntos <= '0;
            vidas  <= VIDAS_INI;
            leds   <= '0;
            fin    <= 1'b0;
        end else begin
            estado <= estado_n;
            dir    <= dir_n;
            pos    <= pos_n;
            cnt    <= cnt_n;
            puntos <= puntos_n;
            vidas  <= vidas_n;
            leds   <= leds_n;
            fin    <= (estado_n == FIN);
        end
    end

    always_comb begin
        estado_n = estado;
        dir_n    = dir;
        pos_n    = pos;
        cnt_n    = cnt;
        puntos_n = puntos;
        vidas_n  = vidas;
        leds_n   = '0;

        case (estado)
            INICIO: begin
                if (boton_pulso) begin
                    estado_n = BARRIDO;
                    pos_n    = '0;
                    dir_n    = SUBE;
                    puntos_n = '0;
                    vidas_n  = VIDAS_INI;
                end
            end
            BARRIDO: begin
                // The button wins over a coincident tick and is judged on the current pos.
                if (boton_pulso) begin
                    cnt_n = '0;
                    if (pos == POS_OBJ) begin
                        estado_n = ACIERTO;
                        if (puntos != '1) puntos_n = puntos + 1'b1;
                    end else begin
                        estado_n = FALLO;
                        vidas_n  = vidas - 1'b1;
                    end
                end else if (paso_pulso) begin
                    if (dir == SUBE) begin
                        if (pos == POS_MAX) begin
                            dir_n = BAJA;
                            pos_n = pos - 1'b1;
                        end else begin
                            pos_n = pos + 1'b1;
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_n = SUBE;
                            pos_n = pos + 1'b1;
                        end else begin
                            pos_n = pos - 1'b1;
                        end
                    end
                end
            end
            ACIERTO, FALLO: begin
                if (paso_pulso) begin
                    if (cnt == FLASH_FIN) begin
                        cnt_n = '0;
                        pos_n = '0;
                        dir_n = SUBE;
                        estado_n = (estado == FALLO && vidas == '0) ? FIN : BARRIDO;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            FIN: begin
                if (boton_pulso) estado_n = INICIO;
            end
            default: begin
                estado_n = INICIO;
            end
        endcase

        // LEDs are registered from the next-state view so they change with the state.
        case (estado_n)
            BARRIDO: leds_n[pos_n] = 1'b1;
            ACIERTO: leds_n = '1;
            FALLO:   leds_n = cnt_n[0] ? PAT_IMPAR : PAT_PAR;
            FIN:     leds_n[PUNTOS_W-1:0] = puntos_n;
            default: leds_n = '0;
        endcase
    end

endmodule

// File: tb/tb_secuenciador_led.sv
// Directed self-checking bench for secuenciador_led (N_LEDS=8, OBJETIVO=3, VIDAS=3, FLASH_PASOS=4).
module tb_secuenciador_led;

`ifdef SECUENCIADOR_LED_ANTIREBOTE_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 3;
`endif

    logic       clock, reset, paso, boton;
    logic [7:0] leds;
    logic [3:0] puntos;
    logic [1:0] vidas;
    logic       fin;

    int checks   = 0;
    int failures = 0;

    int sweep_pos [20] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6};

    secuenciador_led #(
        .N_LEDS      (8),
        .OBJETIVO    (3),
        .VIDAS       (3),
        .FLASH_PASOS (4)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .paso   (paso),
        .boton  (boton),
        .leds   (leds),
        .puntos (puntos),
        .vidas  (vidas),
        .fin    (fin)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic ck(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        paso = 1'b1;
        ck(3);
        paso = 1'b0;
        ck(3);
    endtask

    task automatic press();
        boton = 1'b1;
        ck(LAT);
        boton = 1'b0;
        ck(4);
    endtask

    task automatic hit();
        tick(); tick(); tick();
        press();
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        reset = 1'b1;
        paso  = 1'b0;
        boton = 1'b0;
        ck(2);
        chk("reset_leds", leds, 0);
        chk("reset_puntos", puntos, 0);
        chk("reset_vidas", vidas, 3);
        chk("reset_fin", fin, 0);
        reset = 1'b0;
        ck(2);

        // Start game with exact button latency
        boton = 1'b1;
        ck(LAT - 1);
        chk("start_before", leds, 0);
        ck(1);
        chk("start_leds", leds, 8'h01);
        boton = 1'b0;
        ck(4);

        // Ping-pong sweep, update exactly three clocks after each paso rise
        for (int i = 0; i < 20; i++) begin
            paso = 1'b1;
            ck(2);
            chk("sweep_hold", leds, 32'(1) << ((i == 0) ? 0 : sweep_pos[i-1]));
            ck(1);
            chk("sweep_step", leds, 32'(1) << sweep_pos[i]);
            paso = 1'b0;
            ck(3);
        end

        // Game over: three misses (pos 6, then pos 0 twice)
        press();
        chk("miss1_vidas", vidas, 2);
        chk("miss1_leds", leds, 8'h55);
        tick();
        chk("miss1_alt1", leds, 8'hAA);
        tick();
        chk("miss1_alt2", leds, 8'h55);
        tick();
        chk("miss1_alt3", leds, 8'hAA);
        tick();
        chk("miss1_back", leds, 8'h01);
        press();
        chk("miss2_vidas", vidas, 1);
        tick(); tick(); tick(); tick();
        chk("miss2_back", leds, 8'h01);
        press();
        chk("miss3_vidas", vidas, 0);
        tick(); tick(); tick();
        chk("miss3_nofin", fin, 0);
        tick();
        chk("fin_flag", fin, 1);
        chk("fin_leds", leds, 8'h00);
        press();
        chk("inicio_fin", fin, 0);
        chk("inicio_leds", leds, 8'h00);
        press();
        chk("restart_leds", leds, 8'h01);
        chk("restart_vidas", vidas, 3);
        chk("restart_puntos", puntos, 0);

        // Hit at the target LED; button ignored during the flash
        tick(); tick(); tick();
        chk("hit_pos3", leds, 8'h08);
        press();
        chk("hit_leds", leds, 8'hFF);
        chk("hit_puntos", puntos, 1);
        tick();
        press();
        chk("hit_ignore_puntos", puntos, 1);
        chk("hit_ignore_leds", leds, 8'hFF);
        tick(); tick();
        chk("hit_flash_end_hold", leds, 8'hFF);
        tick();
        chk("hit_back", leds, 8'h01);

        // Collision: button and tick pulses on the same clock at pos 3
        tick(); tick(); tick();
        chk("coll_pos3", leds, 8'h08);
        boton = 1'b1;
        ck(LAT - 3);
        paso = 1'b1;
        ck(2);
        chk("coll_before", leds, 8'h08);
        ck(1);
        chk("coll_leds", leds, 8'hFF);
        chk("coll_puntos", puntos, 2);
        boton = 1'b0;
        paso  = 1'b0;
        ck(4);
        tick(); tick(); tick(); tick();
        chk("coll_back", leds, 8'h01);

        // Score saturation at 15
        for (int k = 3; k <= 16; k++) begin
            hit();
            chk("sat_puntos", puntos, (k > 15) ? 15 : k);
        end
        chk("sat_back", leds, 8'h01);

`ifdef SECUENCIADOR_LED_ANTIREBOTE_EN
        // Short glitch is filtered out
        boton = 1'b1;
        ck(10);
        boton = 1'b0;
        ck(25);
        chk("glitch_leds", leds, 8'h01);
        chk("glitch_vidas", vidas, 3);
        // A long press yields exactly one judgment after 18 clocks
        boton = 1'b1;
        ck(17);
        chk("deb_before", vidas, 3);
        ck(1);
        boton = 1'b1;
        ck(2);
        boton = 1'b0;
        ck(4);
`else
        press();
`endif
        chk("miss4_vidas", vidas, 2);
        chk("miss4_leds", leds, 8'h55);

        // Asynchronous reset between clock edges in the middle of a flash
        tick();
        chk("pre_reset_leds", leds, 8'hAA);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_leds", leds, 0);
        chk("arst_puntos", puntos, 0);
        chk("arst_vidas", vidas, 3);
        chk("arst_fin", fin, 0);
        ck(1);
        reset = 1'b0;
        ck(2);
        chk("post_reset_leds", leds, 0);
        press();
        chk("post_reset_start", leds, 8'h01);
        chk("post_reset_vidas", vidas, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/secuenciador_led.md
SECUENCIADOR_LED -- requirements
Module: secuenciador_led

Interface
REQ-001 SHALL have parameter N_LEDS, default 8, number of LEDs in the sweep (4..16).
REQ-002 SHALL have parameter OBJETIVO, default 3, index of the target LED (0..N_LEDS-1).
REQ-003 SHALL have parameter VIDAS, default 3, lives per game (1..3).
REQ-004 SHALL have parameter FLASH_PASOS, default 4, duration of the hit/miss flash, counted in paso ticks.
REQ-005 SHALL have port clock, input, 1 bit: the single system clock. All logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port paso, input, 1 bit: slow square wave from the frequency divider output, asynchronous to the logic.
REQ-008 SHALL have port boton, input, 1 bit: raw player pushbutton, active-high.
REQ-009 SHALL have port leds, output, N_LEDS bits: registered LED pattern.
REQ-010 SHALL have port puntos, output, 4 bits: score.
REQ-011 SHALL have port vidas, output, 2 bits: remaining lives.
REQ-012 SHALL have port fin, output, 1 bit: high while in the FIN state.

Function
REQ-013 SHALL synchronize paso and boton with two flip-flops each, then detect rising edges, producing a one-clock pulse per edge.
- paso tick latency: 3 clocks from the paso rise to the leds update.
- boton press latency: 3 clocks.
REQ-014 SHALL implement five states: INICIO, BARRIDO, ACIERTO, FALLO, FIN.
REQ-015 INICIO SHALL behave as follows.
- leds all 0.
- On a boton pulse: go to BARRIDO with pos=0, dir=up, puntos=0, vidas=VIDAS.
REQ-016 BARRIDO SHALL behave as follows.
- leds is one-hot at pos.
- Each paso tick moves pos by ±1 in ping-pong fashion.
- At pos=N_LEDS-1 while going up: dir flips and the next pos is N_LEDS-2.
- At pos=0 while going down: dir flips and the next pos is 1.
REQ-017 A boton pulse in BARRIDO SHALL be judged against the current pos.
- pos==OBJETIVO: go to ACIERTO; puntos increments, saturating at 15.
- Otherwise: go to FALLO; vidas decrements.
REQ-018 If a boton pulse and a paso tick coincide in BARRIDO, the boton SHALL win: judged on the pre-advance pos, and pos does not advance that cycle.
REQ-019 ACIERTO SHALL drive leds all 1; FALLO SHALL alternate leds between even-bit and odd-bit patterns on each paso tick.
REQ-020 ACIERTO and FALLO SHALL last exactly FLASH_PASOS paso ticks and ignore boton.
- At the end, go to BARRIDO with pos=0, dir=up.
- Exception: FALLO with vidas==0 goes to FIN.
REQ-021 FIN SHALL behave as follows.
- leds[3:0]=puntos; the upper bits are 0.
- fin=1.
- A boton pulse goes to INICIO.
REQ-022 Unreachable state encodings SHALL recover to INICIO on the next clock.

Reset
REQ-023 On reset assertion, without waiting for a clock edge, the block SHALL set:
- state=INICIO, leds=0, puntos=0, vidas=VIDAS, fin=0;
- pos=0, dir=up, flash counter=0, synchronizer and edge registers=0.
REQ-024 A reset asserted mid-game or mid-flash SHALL discard all game state; operation resumes on the first clock after deassertion.

Configuration
REQ-025 With macro SECUENCIADOR_LED_ANTIREBOTE_EN defined, a boton press SHALL be accepted only after the synchronized level has stayed high for 16 consecutive clocks.
- One pulse per press; release rearms the filter.
- boton latency becomes 18 clocks.
REQ-026 Without SECUENCIADOR_LED_ANTIREBOTE_EN, the boton path SHALL be the plain synchronizer plus edge detector, and no filter logic shall be present.

Structure
REQ-027 State encodings, the 4-bit puntos width and the 2-bit vidas width SHALL live in the shared package secuenciador_led_pkg.
REQ-028 The synchronizer and edge detector SHALL be the sub-module sincronizador_flanco, instantiated once for paso and once for boton.

Verification
REQ-029 The bench SHALL cover these directed scenarios (N_LEDS=8, OBJETIVO=3, VIDAS=3, FLASH_PASOS=4):
- Sweep: press boton, then apply 20 paso rises → pos sequence 0,1,…,7,6,…,0,1,…; leds one-hot; each update 3 clocks after the paso rise.
- Hit: press boton at pos=3 → ACIERTO, leds=8'hFF, puntos=1; after 4 ticks → BARRIDO at pos=0.
- Game over: three presses at pos≠3 → vidas 3→2→1→0; after the third flash fin=1 and leds=8'h00 (puntos=0); press boton → INICIO.
- Collision: boton and paso pulses in the same clock at pos=3 → hit scored, pos stays 3; hit at pos=3 with puntos=15 → puntos stays 15.
- Reset: assert reset mid-FALLO, between clock edges → all outputs reach their reset values immediately, vidas=3.
- Debounce (SECUENCIADOR_LED_ANTIREBOTE_EN): a 10-clock boton glitch → no action; a 20-clock press → exactly one judgment.
